// File: rtl/cpu_defs_pkg.sv
// Shared types for the accumulator CPU: opcodes, ALU selects and sequencer states.
// Also holds a helper that classifies the states which own the memory bus.
package cpu_defs_pkg;

  typedef enum logic [2:0] {
    OP_LOAD  = 3'b000,
    OP_STORE = 3'b001,
    OP_ADD   = 3'b010,
    OP_SUB   = 3'b011,
    OP_BNE   = 3'b100,
    OP_AND   = 3'b101,
    OP_JMP   = 3'b110,
    OP_HALT  = 3'b111
  } opcode_t;

  typedef enum logic [1:0] {
    ALU_PASS = 2'b00,
    ALU_ADD  = 2'b01,
    ALU_SUB  = 2'b10,
    ALU_AND  = 2'b11
  } alu_sel_t;

  typedef enum logic [3:0] {
    IDLE,
    FETCH0,
    FETCH1,
    FETCH2,
    DECODE,
    OPRD,
    EXEC,
    STWR0,
    STWR1,
    BRANCH,
    HALT
  } seq_state_t;

  // States that hold cs and wait on the mem_ready handshake.
  function automatic logic is_mem_state(input seq_state_t s);
    return (s == FETCH1) || (s == OPRD) || (s == STWR1);
  endfunction

endpackage

// File: rtl/cpu_sequencer_mem_wait_timer.sv
// Bounded wait counter for a memory handshake; flags the last allowed wait cycle.
// Kept standalone so a bus arbiter can share the same timeout behaviour.
module mem_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clock,
  input  logic n_reset,
  input  logic start,
  input  logic busy,
  input  logic ready,
  output logic timeout
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] LAST = CW'(MAX_WAIT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      count <= '0;
    end else if (start) begin
      count <= '0;
    end else if (busy && !ready) begin
      count <= count + 1'b1;
    end
  end

  // count holds the number of low cycles already spent, so LAST marks the MAX_WAIT-th cycle.
  assign timeout = busy && !ready && (count == LAST);

endmodule

// File: rtl/cpu_sequencer.sv
// Moore control unit for the 8-bit accumulator CPU: fetch/decode/execute sequencing
// with a bounded memory wait and a sticky bus-error halt.
//
// state  | meaning
// IDLE   | after reset, nothing driven
// FETCH0 | PC -> MAR, PC increments, instruction boundary
// FETCH1 | instruction read from memory into MDR
// FETCH2 | MDR -> IR
// DECODE | IR address field -> MAR, branch on opcode
// OPRD   | operand read from memory into MDR
// EXEC   | MDR through ALU -> ACC
// STWR0  | ACC -> MDR
// STWR1  | MDR written to memory
// BRANCH | IR address field -> PC
// HALT   | stopped; run resumes unless a bus error occurred
module cpu_sequencer
  import cpu_defs_pkg::*;
#(
  parameter int OP_W     = 3,
  parameter int MAX_WAIT = 15
) (
  input  logic            clock,
  input  logic            n_reset,
  input  logic [OP_W-1:0] op,
  input  logic            z_flag,
  input  logic            mem_ready,
  input  logic            run,
  output logic            pc_bus,
  output logic            load_mar,
  output logic            inc_pc,
  output logic            load_pc,
  output logic            addr_bus,
  output logic            load_mdr,
  output logic            mdr_bus,
  output logic            load_ir,
  output logic            acc_bus,
  output logic            load_acc,
  output logic            cs,
  output logic            r_nw,
  output logic [1:0]      alu_sel,
  output logic            fetch,
  output logic            halted,
  output logic            bus_err
);

  seq_state_t state, state_nxt;
  opcode_t    opc;
  logic       timeout;
  logic       wait_start;

  assign opc = opcode_t'(op[2:0]);

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state   <= IDLE;
      bus_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (timeout) bus_err <= 1'b1;
    end
  end

  assign wait_start = is_mem_state(state_nxt) && (state_nxt != state);

  mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait (
    .clock   (clock),
    .n_reset (n_reset),
    .start   (wait_start),
    .busy    (is_mem_state(state)),
    .ready   (mem_ready),
    .timeout (timeout)
  );

  always_comb begin
    state_nxt = state;
    pc_bus    = 1'b0;
    load_mar  = 1'b0;
    inc_pc    = 1'b0;
    load_pc   = 1'b0;
    addr_bus  = 1'b0;
    load_mdr  = 1'b0;
    mdr_bus   = 1'b0;
    load_ir   = 1'b0;
    acc_bus   = 1'b0;
    load_acc  = 1'b0;
    cs        = 1'b0;
    r_nw      = 1'b1;
    alu_sel   = ALU_PASS;
    fetch     = 1'b0;
    halted    = 1'b0;

    case (state)
      IDLE: state_nxt = FETCH0;
      FETCH0: begin
        pc_bus    = 1'b1;
        load_mar  = 1'b1;
        inc_pc    = 1'b1;
        fetch     = 1'b1;
        state_nxt = FETCH1;
      end
      FETCH1: begin
        cs       = 1'b1;
        load_mdr = 1'b1;
        if (mem_ready)    state_nxt = FETCH2;
        else if (timeout) state_nxt = HALT;
      end
      FETCH2: begin
        mdr_bus   = 1'b1;
        load_ir   = 1'b1;
        state_nxt = DECODE;
      end
      DECODE: begin
        addr_bus = 1'b1;
        load_mar = 1'b1;
        case (opc)
          OP_LOAD, OP_ADD, OP_SUB, OP_AND: state_nxt = OPRD;
          OP_STORE: state_nxt = STWR0;
          OP_JMP:   state_nxt = BRANCH;
          OP_BNE:   state_nxt = z_flag ? FETCH0 : BRANCH;
          OP_HALT:  state_nxt = HALT;
          default:  state_nxt = HALT;
        endcase
      end
      OPRD: begin
        cs       = 1'b1;
        load_mdr = 1'b1;
        if (mem_ready)    state_nxt = EXEC;
        else if (timeout) state_nxt = HALT;
      end
      EXEC: begin
        mdr_bus  = 1'b1;
        load_acc = 1'b1;
        case (opc)
          OP_ADD:  alu_sel = ALU_ADD;
          OP_SUB:  alu_sel = ALU_SUB;
          OP_AND:  alu_sel = ALU_AND;
          default: alu_sel = ALU_PASS;
        endcase
        state_nxt = FETCH0;
      end
      STWR0: begin
        acc_bus   = 1'b1;
        load_mdr  = 1'b1;
        state_nxt = STWR1;
      end
      STWR1: begin
        cs   = 1'b1;
        r_nw = 1'b0;
        if (mem_ready)    state_nxt = FETCH0;
        else if (timeout) state_nxt = HALT;
      end
      BRANCH: begin
        addr_bus  = 1'b1;
        load_pc   = 1'b1;
        state_nxt = FETCH0;
      end
      HALT: begin
        halted = 1'b1;
        // A timed-out bus cannot be trusted again until reset.
        if (run && !bus_err) state_nxt = FETCH0;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: each issued instruction queues its expected
// cycle count, state trace and write-cycle count; a monitor checks them at instruction boundaries.
module tb_cpu_sequencer;
  import cpu_defs_pkg::*;

  logic       clock = 1'b0;
  logic       n_reset = 1'b0;
  logic [2:0] op;
  logic       z_flag, mem_ready, run;
  logic       pc_bus, load_mar, inc_pc, load_pc, addr_bus, load_mdr, mdr_bus, load_ir;
  logic       acc_bus, load_acc, cs, r_nw, fetch, halted, bus_err;
  logic [1:0] alu_sel;

  cpu_sequencer #(.OP_W(3), .MAX_WAIT(15)) dut (
    .clock(clock), .n_reset(n_reset), .op(op), .z_flag(z_flag), .mem_ready(mem_ready), .run(run),
    .pc_bus(pc_bus), .load_mar(load_mar), .inc_pc(inc_pc), .load_pc(load_pc), .addr_bus(addr_bus),
    .load_mdr(load_mdr), .mdr_bus(mdr_bus), .load_ir(load_ir), .acc_bus(acc_bus), .load_acc(load_acc),
    .cs(cs), .r_nw(r_nw), .alu_sel(alu_sel), .fetch(fetch), .halted(halted), .bus_err(bus_err)
  );

  always #5 clock = ~clock;

  logic [16:0] vec;
  assign vec = {pc_bus, load_mar, inc_pc, load_pc, addr_bus, load_mdr, mdr_bus, load_ir,
                acc_bus, load_acc, cs, r_nw, alu_sel, fetch, halted, bus_err};
  localparam logic [16:0] RST_VEC = 17'h00020;

  typedef struct {
    string       name;
    int          cycles;
    logic [31:0] trace;
    int          wr;
    logic        halt_end;
    logic        berr;
  } rec_t;

  rec_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle state code from the full strobe vector (bus_err masked); F = illegal combination.
  function automatic logic [3:0] classify(input logic [16:0] v);
    case (v & 17'h1FFFE)
      17'h1C024: return 4'h1;  // FETCH0
      17'h00860: return 4'h2;  // FETCH1 / OPRD
      17'h00620: return 4'h3;  // FETCH2
      17'h09020: return 4'h4;  // DECODE
      17'h004A0: return 4'h5;  // EXEC pass
      17'h004A8: return 4'hA;  // EXEC add
      17'h004B0: return 4'hB;  // EXEC sub
      17'h004B8: return 4'hC;  // EXEC and
      17'h00920: return 4'h6;  // STWR0
      17'h00040: return 4'h7;  // STWR1
      17'h03020: return 4'h8;  // BRANCH
      17'h00022: return 4'h9;  // HALT
      default:   return 4'hF;
    endcase
  endfunction

  // Monitor
  int          m_cyc, m_wr;
  logic [31:0] m_trace;
  logic [3:0]  m_last;
  logic        m_in = 1'b0;

  task automatic close_rec(input logic h);
    rec_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL sb_underflow: got an instruction boundary, required none");
    end else begin
      e = sb.pop_front();
      chk({e.name, ".cycles"}, m_cyc, e.cycles);
      chk({e.name, ".trace"}, m_trace, e.trace);
      chk({e.name, ".wr_cycles"}, m_wr, e.wr);
      chk({e.name, ".halt_end"}, {31'b0, h}, {31'b0, e.halt_end});
      chk({e.name, ".bus_err"}, {31'b0, bus_err}, {31'b0, e.berr});
    end
  endtask

  always @(negedge clock) begin
    logic [3:0] code;
    code = classify(vec);
    if (!n_reset) begin
      m_in = 1'b0;
    end else if (fetch) begin
      if (m_in) close_rec(1'b0);
      m_in    = 1'b1;
      m_cyc   = 1;
      m_trace = {28'h0, code};
      m_last  = code;
      m_wr    = 0;
    end else if (halted) begin
      if (m_in) close_rec(1'b1);
      m_in = 1'b0;
    end else if (m_in) begin
      m_cyc++;
      if (code != m_last) begin
        m_trace = {m_trace[27:0], code};
        m_last  = code;
      end
      if (cs && !r_nw) m_wr++;
    end
  end

  // Memory model: fw/dw low cycles before ready for the fetch / data access.
  int   fw = 0, dw = 0, wl = 0, acc_idx = 0;
  logic prev_cs = 1'b0, idle_val = 1'b0;

  always @(negedge clock) begin
    idle_val = ~idle_val;
    if (fetch) acc_idx = 0;
    if (cs && !prev_cs) begin
      wl = (acc_idx == 0) ? fw : dw;
      acc_idx++;
    end
    if (cs) begin
      mem_ready = (wl == 0);
      if (wl > 0) wl--;
    end else begin
      mem_ready = idle_val;  // outside memory states the handshake must be ignored
    end
    prev_cs = cs;
  end

  task automatic wait_fetch(output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!fetch && n < 100);
    if (!fetch) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_fetch: got no fetch in %0d cycles, required one", n);
    end
  endtask

  task automatic wait_halt();
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!halted && n < 100);
    if (!halted) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_halt: got halted=0 after %0d cycles, required 1", n);
    end
  endtask

  task automatic setup(input string nm, input opcode_t o, input logic z, input int f, input int d,
                       input int cyc, input logic [31:0] tr, input int wr, input logic h,
                       input logic be, input bit push);
    rec_t r;
    op     = o;
    z_flag = z;
    fw     = f;
    dw     = d;
    if (push) begin
      r.name     = nm;
      r.cycles   = cyc;
      r.trace    = tr;
      r.wr       = wr;
      r.halt_end = h;
      r.berr     = be;
      sb.push_back(r);
    end
  endtask

  task automatic issue(input string nm, input opcode_t o, input logic z, input int f, input int d,
                       input int cyc, input logic [31:0] tr, input int wr, input logic h,
                       input logic be, input bit push);
    int n;
    wait_fetch(n);
    setup(nm, o, z, f, d, cyc, tr, wr, h, be, push);
  endtask

  initial begin
    int   n;
    logic hold;
    op        = OP_LOAD;
    z_flag    = 1'b0;
    run       = 1'b0;
    mem_ready = 1'b0;
    #12;
    chk("reset_vec", {15'b0, vec}, {15'b0, RST_VEC});
    @(negedge clock);
    #2 n_reset = 1'b1;
    wait_fetch(n);
    chk("first_fetch_latency", n, 1);
    setup("load", OP_LOAD, 0, 0, 0, 6, 32'h123425, 0, 0, 0, 1);
    issue("add", OP_ADD, 0, 0, 0, 6, 32'h12342A, 0, 0, 0, 1);
    issue("sub_waits", OP_SUB, 0, 1, 2, 9, 32'h12342B, 0, 0, 0, 1);
    issue("and", OP_AND, 0, 0, 0, 6, 32'h12342C, 0, 0, 0, 1);
    issue("store_wait3", OP_STORE, 0, 0, 3, 9, 32'h123467, 4, 0, 0, 1);
    issue("bne_taken", OP_BNE, 0, 0, 0, 5, 32'h12348, 0, 0, 0, 1);
    issue("bne_untaken", OP_BNE, 1, 0, 0, 4, 32'h1234, 0, 0, 0, 1);
    issue("jmp", OP_JMP, 1, 0, 0, 5, 32'h12348, 0, 0, 0, 1);
    issue("halt", OP_HALT, 0, 0, 0, 4, 32'h1234, 0, 1, 0, 1);
    wait_halt();
    hold = 1'b1;
    repeat (10) begin
      @(negedge clock);
      if (!halted) hold = 1'b0;
    end
    chk("halt_hold_10", {31'b0, hold}, 32'h1);
    run = 1'b1;
    @(negedge clock);
    chk("resume_fetch_halted", {30'b0, fetch, halted}, 32'h2);
    setup("load_run_high", OP_LOAD, 0, 0, 0, 6, 32'h123425, 0, 0, 0, 1);
    issue("fetch_timeout", OP_LOAD, 0, 100, 0, 16, 32'h12, 0, 1, 1, 1);
    wait_halt();
    chk("bus_err_set", {31'b0, bus_err}, 32'h1);
    repeat (5) @(negedge clock);
    chk("run_ignored_on_err", {30'b0, halted, fetch}, 32'h2);
    n_reset = 1'b0;
    run     = 1'b0;
    #1;
    chk("reset_clears_err", {15'b0, vec}, {15'b0, RST_VEC});
    @(negedge clock);
    #2 n_reset = 1'b1;
    issue("ready_in_cycle15", OP_LOAD, 0, 14, 0, 20, 32'h123425, 0, 0, 0, 1);
    issue("add_aborted", OP_ADD, 0, 0, 5, 0, 32'h0, 0, 0, 0, 0);
    repeat (4) @(negedge clock);
    chk("in_oprd", {15'b0, vec}, 32'h00860);
    #2 n_reset = 1'b0;
    #1;
    chk("async_abort_vec", {15'b0, vec}, {15'b0, RST_VEC});
    chk("async_abort_cs", {31'b0, cs}, 32'h0);
    @(negedge clock);
    #2 n_reset = 1'b1;
    wait_fetch(n);
    chk("restart_latency", n, 1);
    setup("restart_load", OP_LOAD, 0, 0, 0, 6, 32'h123425, 0, 0, 0, 1);
    issue("restart_store", OP_STORE, 0, 0, 0, 6, 32'h123467, 1, 0, 0, 1);
    wait_fetch(n);
    repeat (2) @(negedge clock);
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test by 200000, required finish");
    $fatal(1);
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Moore-style control unit for the basic 8-bit accumulator CPU. It sequences fetch, decode and execute over the PC/MAR/MDR/IR/ACC datapath and the shared memory bus. It waits on a memory-ready handshake, with a bounded wait and a bus-error halt. It sits inside the CPU top level between the instruction register's opcode field and the datapath load/bus-enable strobes.

## Interface
- OP_W, 3, opcode width; the opcode map below requires 3
- MAX_WAIT, 15, maximum consecutive cycles spent in a memory state with mem_ready low (≥1)
- clock  input  1  system clock, rising edge
- n_reset  input  1  asynchronous, active-low reset
- op  input  OP_W  opcode field of IR; valid from DECODE onward
- z_flag  input  1  ACC==0 flag from datapath
- mem_ready  input  1  memory completes the current access this cycle
- run  input  1  resume request while halted
- pc_bus, load_mar, inc_pc, load_pc, addr_bus, load_mdr, mdr_bus, load_ir, acc_bus, load_acc  output  1 each  datapath strobes
- cs  output  1  memory chip select
- r_nw  output  1  1 = read, 0 = write
- alu_sel  output  2  00 PASS, 01 ADD, 10 SUB, 11 AND
- fetch  output  1  instruction-boundary marker
- halted  output  1  in HALT state
- bus_err  output  1  sticky memory-timeout flag

## Operation
- Opcodes: 000 LOAD, 001 STORE, 010 ADD, 011 SUB, 100 BNE, 101 AND, 110 JMP, 111 HALT.
- All outputs decode from the state alone, except bus_err, which is a register. Any strobe not listed for a state is 0; r_nw is 1 everywhere except STWR1.
- IDLE: nothing asserted; goes to FETCH0.
- FETCH0: pc_bus, load_mar, inc_pc, fetch; goes to FETCH1.
- FETCH1: cs, load_mdr; goes to FETCH2 on mem_ready.
- FETCH2: mdr_bus, load_ir; goes to DECODE.
- DECODE: addr_bus, load_mar. Next state by opcode:
  - LOAD/ADD/SUB/AND go to OPRD.
  - STORE goes to STWR0.
  - JMP goes to BRANCH.
  - BNE goes to BRANCH if z_flag=0, otherwise FETCH0.
  - HALT goes to HALT.
- OPRD: cs, load_mdr; goes to EXEC on mem_ready.
- EXEC: mdr_bus, load_acc, alu_sel per opcode (LOAD→00, ADD→01, SUB→10, AND→11); goes to FETCH0.
- STWR0: acc_bus, load_mdr; goes to STWR1.
- STWR1: cs, r_nw=0; goes to FETCH0 on mem_ready.
- BRANCH: addr_bus, load_pc; goes to FETCH0.
- HALT: halted. If run=1 and bus_err=0, goes to FETCH0; otherwise stays.
- Memory states are FETCH1, OPRD and STWR1.
  - load_mdr stays high for the whole read state; the MDR value captured on the mem_ready edge is final.
  - mem_ready is ignored outside memory states.
- Wait counter, width $clog2(MAX_WAIT+1):
  - Clears on entry to any memory state.
  - Increments each cycle mem_ready=0.
  - If mem_ready=0 in the MAX_WAIT-th cycle of a memory state, next state is HALT and bus_err is set on the same edge.
  - mem_ready=1 in that same cycle completes normally.
- bus_err is cleared only by reset. run is ignored outside HALT.

## Timing
- Reset: asynchronous entry to IDLE. Every output is 0 except r_nw=1; the wait counter and bus_err are 0.
- First FETCH0 occurs one cycle after n_reset deasserts.
- Reset mid-access, including during STWR1, aborts immediately; cs drops asynchronously.
- Zero-wait cycle counts, FETCH0 to the next FETCH0:
  - LOAD/ADD/SUB/AND/STORE: 6.
  - JMP and taken BNE: 5.
  - Untaken BNE: 4.
  - HALT: 4 cycles to reach HALT.
- Each mem_ready-low cycle adds 1. Worst case per memory state is MAX_WAIT cycles.
- HALT with run=1 reaches FETCH0 on the next edge. run held high continuously is allowed.

## Structure
- Shared package cpu_defs_pkg holds:
  - opcode_t enum (values above);
  - alu_sel_t enum;
  - seq_state_t enum (IDLE, FETCH0, FETCH1, FETCH2, DECODE, OPRD, EXEC, STWR0, STWR1, BRANCH, HALT).
- One module, with a state register, a wait counter and an output decode block.
- An optional sub-module, mem_wait_timer, holds the counter and timeout compare. It is reused by a future DMA/bus arbiter.

## Test plan
- Reset, then op=000 LOAD with mem_ready tied 1: state order IDLE, F0, F1, F2, DECODE, OPRD, EXEC, F0; alu_sel=00 and load_acc=1 only in EXEC; fetch pulses every 6 cycles.
- op=001 STORE, mem_ready low for 3 cycles in STWR1: r_nw=0 with cs=1 for exactly 4 cycles; acc_bus asserted only in STWR0; 9 cycles total.
- op=100 BNE with z_flag=0: load_pc in BRANCH, 5-cycle instruction. With z_flag=1: no load_pc, 4 cycles.
- op=111 HALT: halted=1 after 4 cycles and holds 10 cycles with run=0. Pulse run=1: FETCH0 on the next cycle and halted=0.
- mem_ready held 0 in FETCH1 with MAX_WAIT=15: HALT after 15 cycles, bus_err=1, run ignored. n_reset low clears bus_err and returns to IDLE. Repeat with mem_ready=1 in cycle 15: normal completion, bus_err stays 0.
- Assert n_reset low mid-OPRD: all strobes drop without waiting for clock; cs=0, r_nw=1; restart fetches cleanly.
